// File: rtl/alu_share_ctrl.sv
// Arbitrates two issue units onto one shared combinational ALU: round-robin grant,
// registered operand drive, fixed settle wait, registered result. Option: ALU_SHARE_SLT_EN.
module alu_share_ctrl #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_set,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // a ready bit never depends on anything but state and the current valids.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;
    logic [3:0] settle_cnt;
    logic       grant;
    logic [2:0] sel_op;
    logic [2:0] drive_op;
`ifdef ALU_SHARE_SLT_EN
    logic       slt_q;
    logic       sel_slt;
`endif

    assign state_dbg = state;

    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) grant = ~last_grant;
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !reset) req_ready = req_valid & (grant ? 2'b10 : 2'b01);
    end

    assign sel_op = grant ? req_op1 : req_op0;

`ifdef ALU_SHARE_SLT_EN
    // Set-less-than rides on a subtract; the ALU's set flag becomes the result.
    assign sel_slt  = (sel_op == 3'b111);
    assign drive_op = sel_slt ? 3'b110 : sel_op;
`else
    assign drive_op = sel_op;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            settle_cnt <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'b0000;
`ifdef ALU_SHARE_SLT_EN
            slt_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        alu_a      <= grant ? req_a1 : req_a0;
                        alu_b      <= grant ? req_b1 : req_b0;
                        alu_op     <= drive_op;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        settle_cnt <= 4'(SETTLE - 1);
`ifdef ALU_SHARE_SLT_EN
                        slt_q      <= sel_slt;
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (settle_cnt == 4'd0) begin
`ifdef ALU_SHARE_SLT_EN
                        rsp_result <= slt_q ? {{(WIDTH-1){1'b0}}, alu_set} : alu_result;
`else
                        rsp_result <= alu_result;
`endif
                        rsp_flags  <= {alu_overflow, alu_set, alu_zero, alu_cout};
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: stands in for the shared ALU, runs directed vectors,
// corner sequences (contention, backpressure, reset in flight) and a random scoreboard run.
module tb_alu_share_ctrl;

    localparam int W      = 32;
    localparam int SETTLE = 2;
`ifdef ALU_SHARE_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]   req_op0, req_op1;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;
    logic         alu_cout, alu_zero, alu_set, alu_overflow;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [1:0]   state_dbg;

    int checks = 0;
    int passes = 0;

    alu_share_ctrl #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .alu_set(alu_set), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // The shared ALU itself: ripple-style carry/overflow, set/zero always from a - b.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [32:0] s, d;
        logic [31:0] r;
        logic c, v, vs, st, z;
        s = {1'b0, a} + {1'b0, b};
        d = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (s[31] != a[31]); end
            3'b110: begin r = d[31:0]; c = d[32]; v = (a[31] != b[31]) && (d[31] != a[31]); end
            default: r = '0;
        endcase
        vs = (a[31] != b[31]) && (d[31] != a[31]);
        st = d[31] ^ vs;
        z  = (d[31:0] == 32'd0);
        return {v, st, z, c, r};
    endfunction

    always_comb {alu_overflow, alu_set, alu_zero, alu_cout, alu_result} = alu_model(alu_a, alu_b, alu_op);

    // Reference response {flags, result} from plain integer arithmetic on the request.
    function automatic logic [35:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        logic [31:0] res;
        logic [2:0] eop;
        logic cout, ovf, st, z;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        eop = (SLT_EN && op == 3'b111) ? 3'b110 : op;
        res = '0; cout = 1'b0; ovf = 1'b0;
        case (eop)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: begin
                res = a + b; cout = (ua + ub) > 64'hFFFF_FFFF;
                sr = sa + sb; ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b110: begin
                res = a - b; cout = (ua >= ub);
                sr = sa - sb; ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            default: res = '0;
        endcase
        if (SLT_EN && op == 3'b111) res = (sa < sb) ? 32'd1 : 32'd0;
        st = (sa < sb);
        z  = (a == b);
        return {ovf, st, z, cout, res};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Returns at the falling edge of the accept cycle.
    task automatic wait_accept(output bit ok, output logic [1:0] rdy);
        ok = 1'b0; rdy = 2'b00;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin ok = 1'b1; rdy = req_ready; end
            else if (i < 29) begin @(posedge clk); #1; end
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int n);
        bit ok;
        logic [1:0] rdy;
        logic [2:0] exp_op;
        exp_op = (SLT_EN && v.op == 3'b111) ? 3'b110 : v.op;
        if (v.id) begin req_a1 = v.a; req_b1 = v.b; req_op1 = v.op; end
        else begin req_a0 = v.a; req_b0 = v.b; req_op0 = v.op; end
        req_valid = v.id ? 2'b10 : 2'b01;
        rsp_ready = 1'b0;
        wait_accept(ok, rdy);
        check($sformatf("v%0d_accept", n), {ok, rdy}, {1'b1, (v.id ? 2'b10 : 2'b01)});
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check($sformatf("v%0d_drive", n), {alu_a, alu_b, alu_op}, {v.a, v.b, exp_op});
        for (int k = 2; k <= SETTLE; k++) @(negedge clk);
        check($sformatf("v%0d_early", n), rsp_valid, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_rsp", n), {rsp_valid, rsp_id, rsp_flags, rsp_result},
              {1'b1, v.id, v.exp_flags, v.exp_res});
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle", n), {rsp_valid, state_dbg}, {1'b0, 2'd0});
        @(posedge clk); #1;
    endtask

    logic [36:0] exp_q[$];
    logic [36:0] e;
    logic [35:0] r;
    bit          ok, busy, lg, g, saw_rsp;
    logic [1:0]  rdy, exp_ready;
    int          cyc, acc_n, acc_cyc[4];
    logic        acc_id[4];

    initial begin
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
        @(negedge clk);
        check("reset_outputs", {req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id},
              {2'b00, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0});
        check("reset_rsp", {rsp_result, rsp_flags, state_dbg}, {32'd0, 4'd0, 2'd0});
        do_reset();

        vecs[0] = '{1'b0, 32'd5, 32'd7, 3'b010, 32'd12, 4'b0100};
        vecs[1] = '{1'b1, 32'd9, 32'd9, 3'b110, 32'd0, 4'b0011};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 4'b1000};
        vecs[3] = '{1'b1, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b000, 32'hF000_000F, 4'b0100};
        vecs[4] = '{1'b0, 32'h1234_0000, 32'h0000_5678, 3'b001, 32'h1234_5678, 4'b0000};
        vecs[5] = '{1'b1, 32'd3, 32'd3, 3'b011, 32'd0, 4'b0010};
        vecs[6] = '{1'b0, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 4'b0100};
        vecs[7] = '{1'b1, 32'hFFFF_FFFD, 32'd4, 3'b111, (SLT_EN ? 32'd1 : 32'd0),
                    (SLT_EN ? 4'b0101 : 4'b0100)};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 4'b0101};
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Contention: both valid continuously, immediate response accept.
        do_reset();
        req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'b010;
        req_a1 = 32'd8; req_b1 = 32'd3; req_op1 = 3'b110;
        req_valid = 2'b11; rsp_ready = 1'b1; acc_n = 0;
        for (int c = 0; c < 40 && acc_n < 4; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                acc_cyc[acc_n] = c; acc_id[acc_n] = req_ready[1]; acc_n++;
            end
            @(posedge clk); #1;
        end
        check("cont_count", acc_n, 4);
        for (int i = 0; i < acc_n; i++) begin
            check($sformatf("cont_id%0d", i), acc_id[i], i % 2);
            if (i > 0) check($sformatf("cont_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], SETTLE + 2);
        end

        // Backpressure: response held for 5 cycles while the other requester waits.
        do_reset();
        req_a0 = 32'd100; req_b0 = 32'd23; req_op0 = 3'b010;
        req_valid = 2'b01;
        wait_accept(ok, rdy);
        check("bp_accept", ok, 1'b1);
        @(posedge clk); #1 req_valid = 2'b11;
        saw_rsp = 1'b0;
        for (int i = 0; i < 20 && !saw_rsp; i++) begin
            @(negedge clk);
            saw_rsp = rsp_valid;
            if (!saw_rsp) begin
                check("bp_ready_exec", req_ready, 2'b00);
                @(posedge clk); #1;
            end
        end
        check("bp_rsp_seen", saw_rsp, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_hold", {rsp_valid, rsp_result, rsp_flags}, {1'b1, 32'd123, 4'd0});
            check("bp_alu_hold", {alu_a, alu_b, alu_op}, {32'd100, 32'd23, 3'b010});
            check("bp_ready_hold", req_ready, 2'b00);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_after", {rsp_valid, state_dbg, req_ready}, {1'b0, 2'd0, 2'b10});

        // Reset while a transaction is in EXEC.
        do_reset();
        req_a0 = 32'd4; req_b0 = 32'd4; req_op0 = 3'b010;
        req_valid = 2'b01;
        wait_accept(ok, rdy);
        check("rst_accept", ok, 1'b1);
        @(posedge clk); #1 req_valid = 2'b00;
        #2 reset = 1'b1;
        #1;
        check("rst_outputs", {alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready},
              {32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd0, 2'b00});
        @(posedge clk); #1 reset = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("rst_no_rsp", saw_rsp, 1'b0);
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        check("rst_next_grant", req_ready, 2'b01);

        // Random traffic against the reference model.
        do_reset();
        busy = 1'b0; lg = 1'b1; cyc = 0;
        for (int n = 0; n < 600; n++) begin
            if (n < 570) begin
                req_valid = 2'($urandom_range(0, 3));
                rsp_ready = ($urandom_range(0, 3) != 0);
                req_a0 = $urandom; req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : $urandom;
                req_a1 = $urandom; req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : $urandom;
                case ($urandom_range(0, 5))
                    0: req_op0 = 3'b000; 1: req_op0 = 3'b001; 2: req_op0 = 3'b010;
                    3: req_op0 = 3'b110; 4: req_op0 = 3'b011; default: req_op0 = 3'b111;
                endcase
                case ($urandom_range(0, 5))
                    0: req_op1 = 3'b000; 1: req_op1 = 3'b001; 2: req_op1 = 3'b010;
                    3: req_op1 = 3'b110; 4: req_op1 = 3'b011; default: req_op1 = 3'b111;
                endcase
            end else begin
                req_valid = 2'b00; rsp_ready = 1'b1;
            end
            @(negedge clk);
            if (busy) cyc++;
            g = (req_valid == 2'b11) ? ~lg : req_valid[1];
            exp_ready = busy ? 2'b00 : (req_valid & (g ? 2'b10 : 2'b01));
            check("rnd_ready", req_ready, exp_ready);
            check("rnd_valid", rsp_valid, busy && (cyc >= SETTLE + 1));
            if (busy && cyc >= SETTLE + 1 && rsp_ready) begin
                if (exp_q.size() == 0) check("rnd_q_nonempty", 1'b0, 1'b1);
                else begin
                    e = exp_q.pop_front();
                    check("rnd_rsp", {rsp_id, rsp_flags, rsp_result}, e);
                end
                busy = 1'b0;
            end else if (|exp_ready) begin
                r = g ? exp_rsp(req_a1, req_b1, req_op1) : exp_rsp(req_a0, req_b0, req_op0);
                exp_q.push_back({g, r});
                lg = g; busy = 1'b1; cyc = 0;
            end
            @(posedge clk); #1;
        end
        check("rnd_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
